mux_arbiter_4x1: RTL and testbench
==================================

# mux_arbiter_4x1

Round-robin arbiter and sequencer for the 4-to-1 32-bit datapath mux. It shares the mux output among four requesters by generating a one-hot grant and the 2-bit select. It registers the selected operand with a valid flag. It sits in front of the shared operand/result bus in the ARM datapath and replaces the free-running select stimulus with a controlled, fair schedule.

## Interface
- WIDTH, 32, data width of each input and of `y`.
- MAX_HOLD, 8, maximum consecutive grant cycles before forced rotation when others are pending; legal range ≥ 2.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  4  request per source; bit k requests input k.
- i0, i1, i2, i3  in  WIDTH each  data sources, mux inputs 0..3.
- gnt  out  4  one-hot grant, registered; all zero when idle.
- sel  out  2  mux select = index of current owner, registered.
- y  out  WIDTH  registered mux output.
- y_valid  out  1  `y` holds data captured from a granted, still-requesting source.

## Operation
- State machine:
  - IDLE: `gnt` = 0.
  - GRANT: exactly one `gnt` bit set; the owner is `o` = `sel`.
- Registered state: `last` (2 bits, last granted index) and `cnt` (hold counter, width max(1, clog2(MAX_HOLD))).
- Round-robin pick over a request vector `v`:
  - search order is `last+1`, `last+2`, `last+3`, `last+4`, all mod 4;
  - the first set bit wins.
- Every new grant loads `gnt` = onehot(winner), `sel` = winner, `last` = winner, `cnt` = 0.
- IDLE: if `req` ≠ 0, pick from `req` and go to GRANT; otherwise stay.
- GRANT, with `others` = `req` & ~onehot(o):
  - `req[o]` = 0 and `others` ≠ 0: pick from `others` and switch owner directly, with no idle cycle.
  - `req[o]` = 0 and `others` = 0: go to IDLE, `gnt` ← 0; `sel` holds its value.
  - `req[o]` = 1 and `cnt` = MAX_HOLD−1, `others` ≠ 0: pick from `others` and switch.
  - `req[o]` = 1 and `cnt` = MAX_HOLD−1, `others` = 0: keep the grant, `cnt` ← 0.
  - otherwise: `cnt` ← `cnt`+1.
- Datapath, every edge:
  - `y_valid` ← |(`gnt` & `req`).
  - If that term is 1, `y` ← input[`sel`]; else `y` holds its value.
- Requests from non-owners never affect `y`.
- Reset (`rst_n` low at an edge) takes priority over everything, including mid-grant. After that edge:
  - state = IDLE, `gnt` = 0, `sel` = 0, `y` = 0, `y_valid` = 0, `cnt` = 0;
  - `last` = 3, so requester 0 has first priority.

## Timing
- `req[k]` sampled high at edge N from IDLE: `gnt[k]` and `sel` = k visible after edge N.
- `y` = input k and `y_valid` = 1 after edge N+1, so request-to-data latency is 2 edges.
- Owner change on a switch edge:
  - `y` captures the old owner at that edge if the old owner is still requesting;
  - the new owner's data appears one edge later.
  - Under continuous contention `y_valid` stays high without gaps.
- Owner drops `req`:
  - at the next edge `y_valid` ← 0 (the sampled `gnt`&`req` term is 0);
  - the grant moves or clears at the same edge.
- With all four requesting, each owner holds exactly MAX_HOLD grant cycles.
- Any requester waits at most 3·MAX_HOLD cycles.
- Inputs `i0`..`i3` are sampled only at clock edges; no combinational path from inputs to outputs.

## Structure
- Shared package `mux_arb_pkg`: state enum (IDLE, GRANT), index width constant (2), requester count constant (4).
- One combinational sub-module `rr_picker`:
  - inputs: 4-bit vector and 2-bit `last`;
  - outputs: 2-bit winner index and `found`.
- The single `rr_picker` instance serves both pick cases, with the vector muxed between `req` and `others`.
- FSM, counter and output registers live in `mux_arbiter_4x1`.

## Test plan
Test values throughout: `i0`=32'h0, `i1`=32'hFFFFFFFF, `i2`=32'hFFFF0000, `i3`=32'h0000FFFF.
- Reset: `rst_n` low for 2 edges with `req`=4'hF → `gnt`=0, `sel`=0, `y`=0, `y_valid`=0.
- Single request: `req`=4'b0100 from IDLE → after edge 1 `gnt`=4'b0100, `sel`=2; after edge 2 `y`=32'hFFFF0000, `y_valid`=1.
- Full contention, MAX_HOLD=4, `req`=4'hF from reset:
  - owners go 0,1,2,3,0, each for 4 cycles;
  - `y` steps 32'h0 → 32'hFFFFFFFF → 32'hFFFF0000 → 32'h0000FFFF;
  - `y_valid` never drops.
- Sole requester past hold limit: `req`=4'b0010 for 20 cycles → `gnt` stays 4'b0010, `cnt` wraps, `y`=32'hFFFFFFFF continuously valid.
- Owner release:
  - owner 0 drops `req` while `req[3]`=1 → next edge `gnt`=4'b1000;
  - repeat with no other requester → `gnt`=0 and `y_valid`=0 next edge, with `y` holding its last value.
- Reset mid-grant: `rst_n` low while owner 2 is granted → all outputs reset at that edge; after release, `req`=4'hF → `gnt`=4'b0001.

Source files
------------

// File: rtl/mux_arbiter_4x1_pkg.sv
// Shared types and constants for the 4-to-1 round-robin mux arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Hold counter width: max(1, clog2(max_hold)).
  function automatic int cnt_width(input int max_hold);
    int w;
    w = $clog2(max_hold);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux_arbiter_4x1_if.sv
// Requester/data bus of the mux arbiter. The master side drives requests and
// operands; the slave side (the arbiter) returns grant, select and the
// registered operand. dbg_state/dbg_cnt expose the FSM for observation.
// Handshake: a source k holding req[k] high is served while gnt[k] is high;
// y carries valid data whenever y_valid is high. Dropping req releases the grant.
interface mux_arbiter_4x1_if
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 8
);
  localparam int CNT_W = cnt_width(MAX_HOLD);

  logic [N_REQ-1:0] req;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic [WIDTH-1:0] i3;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] sel;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  state_e           dbg_state;
  logic [CNT_W-1:0] dbg_cnt;

  modport master (
    output req, i0, i1, i2, i3,
    input  gnt, sel, y, y_valid, dbg_state, dbg_cnt
  );

  modport slave (
    input  req, i0, i1, i2, i3,
    output gnt, sel, y, y_valid, dbg_state, dbg_cnt
  );

endinterface

// File: rtl/mux_arbiter_4x1_rr_picker.sv
// Combinational round-robin picker: scans last+1 .. last+4 (mod 4) and
// returns the first set bit of the vector.
module rr_picker
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_vec,
  input  logic [IDX_W-1:0] i_last,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  // First set bit in rotating order starting just after the last winner.
  always_comb begin
    logic [IDX_W-1:0] w_cand;
    o_idx   = '0;
    o_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = i_last + IDX_W'(k);
      if (!o_found && i_vec[w_cand]) begin
        o_idx   = w_cand;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter_4x1.sv
// Round-robin arbiter and sequencer for the shared 4-to-1 operand mux.
// Grants one requester at a time, limits consecutive ownership to MAX_HOLD
// cycles when others wait, and registers the selected operand with a valid flag.
module mux_arbiter_4x1
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 8
)(
  input  logic              clk,
  input  logic              rst_n,
  mux_arbiter_4x1_if.slave  bus
);

  localparam int               CNT_W   = cnt_width(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  state_e           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [IDX_W-1:0] r_sel;
  logic [IDX_W-1:0] r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_y;
  logic             r_y_valid;

  logic [N_REQ-1:0] w_owner_oh;
  logic [N_REQ-1:0] w_others;
  logic [N_REQ-1:0] w_pick_vec;
  logic [IDX_W-1:0] w_win;
  logic             w_found;
  logic             w_serve;
  logic [WIDTH-1:0] w_sel_data;

  assign w_owner_oh = N_REQ'(1) << r_sel;
  assign w_others   = bus.req & ~w_owner_oh;
  // One picker serves both cases: fresh pick from IDLE, hand-off in GRANT.
  assign w_pick_vec = (r_state == ST_GRANT) ? w_others : bus.req;
  assign w_serve    = |(r_gnt & bus.req);

  rr_picker u_picker (
    .i_vec   (w_pick_vec),
    .i_last  (r_last),
    .o_idx   (w_win),
    .o_found (w_found)
  );

  // Operand select from the registered owner index.
  always_comb begin
    w_sel_data = bus.i0;
    case (r_sel)
      2'd0:    w_sel_data = bus.i0;
      2'd1:    w_sel_data = bus.i1;
      2'd2:    w_sel_data = bus.i2;
      default: w_sel_data = bus.i3;
    endcase
  end

  // Arbitration FSM: grant, hold counter, forced rotation and release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_last  <= 2'd3;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_GRANT;
            r_gnt   <= N_REQ'(1) << w_win;
            r_sel   <= w_win;
            r_last  <= w_win;
            r_cnt   <= '0;
          end
        end
        default: begin
          if (!bus.req[r_sel] || (r_cnt == CNT_MAX)) begin
            if (w_found) begin
              // Owner released or used up its hold budget with others waiting.
              r_gnt  <= N_REQ'(1) << w_win;
              r_sel  <= w_win;
              r_last <= w_win;
              r_cnt  <= '0;
            end else if (!bus.req[r_sel]) begin
              // Nobody left: drop to idle, select keeps its value.
              r_state <= ST_IDLE;
              r_gnt   <= '0;
              r_cnt   <= '0;
            end else begin
              // Sole requester at the limit keeps the grant; counter wraps.
              r_cnt <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Output register: capture the owner's operand while it is still requesting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_y_valid <= w_serve;
      if (w_serve) begin
        r_y <= w_sel_data;
      end
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.sel       = r_sel;
  assign bus.y         = r_y;
  assign bus.y_valid   = r_y_valid;
  assign bus.dbg_state = r_state;
  assign bus.dbg_cnt   = r_cnt;

endmodule

// File: tb/tb_mux_arbiter_4x1.sv
// Directed bench for mux_arbiter_4x1 with MAX_HOLD = 4.
module tb_mux_arbiter_4x1;
  import mux_arb_pkg::*;

  localparam int WIDTH = 32;
  localparam int MH    = 4;

  logic clk;
  logic rst_n;

  mux_arbiter_4x1_if #(.WIDTH(WIDTH), .MAX_HOLD(MH)) bus ();

  mux_arbiter_4x1 #(.WIDTH(WIDTH), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] din [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Driver tasks: advance one edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [3:0] r);
    bus.req = r;
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] g, input logic [1:0] s,
                               input logic [31:0] yy, input logic yv);
    check({tag, ".gnt"},     32'(bus.gnt),     32'(g));
    check({tag, ".sel"},     32'(bus.sel),     32'(s));
    check({tag, ".y"},       bus.y,            yy);
    check({tag, ".y_valid"}, 32'(bus.y_valid), 32'(yv));
  endtask

  initial begin
    din[0] = 32'h0000_0000;
    din[1] = 32'hFFFF_FFFF;
    din[2] = 32'hFFFF_0000;
    din[3] = 32'h0000_FFFF;
    bus.i0 = din[0];
    bus.i1 = din[1];
    bus.i2 = din[2];
    bus.i3 = din[3];
    rst_n  = 1'b0;
    drive_req(4'hF);

    // Reset held two edges with all requesting.
    #1;
    step();
    step();
    check_outputs("reset", 4'b0000, 2'd0, 32'h0, 1'b0);
    check("reset.state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("reset.cnt",   32'(bus.dbg_cnt),   32'd0);

    // Single request from idle: grant after 1 edge, data after 2.
    rst_n = 1'b1;
    drive_req(4'b0100);
    step();
    check("single.e1.gnt",     32'(bus.gnt),     32'b0100);
    check("single.e1.sel",     32'(bus.sel),     32'd2);
    check("single.e1.y_valid", 32'(bus.y_valid), 32'd0);
    step();
    check_outputs("single.e2", 4'b0100, 2'd2, 32'hFFFF_0000, 1'b1);
    drive_req(4'b0000);
    step();
    check_outputs("single.release", 4'b0000, 2'd2, 32'hFFFF_0000, 1'b0);
    check("single.release.state", 32'(bus.dbg_state), 32'(ST_IDLE));

    // Full contention from reset: each owner holds MH cycles, 0,1,2,3,0.
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    drive_req(4'hF);
    for (int k = 1; k <= 20; k++) begin
      int owner;
      owner = ((k - 1) / MH) % 4;
      step();
      check($sformatf("cont.k%0d.gnt", k), 32'(bus.gnt), 32'(4'b0001 << owner));
      check($sformatf("cont.k%0d.sel", k), 32'(bus.sel), 32'(owner));
      check($sformatf("cont.k%0d.cnt", k), 32'(bus.dbg_cnt), 32'((k - 1) % MH));
      if (k >= 2) begin
        check($sformatf("cont.k%0d.y", k), bus.y, din[((k - 2) / MH) % 4]);
        check($sformatf("cont.k%0d.y_valid", k), 32'(bus.y_valid), 32'd1);
      end
    end

    // Sole requester past the hold limit: owner 0 drops, 1 takes over directly.
    drive_req(4'b0010);
    step();
    check("sole.switch.gnt",     32'(bus.gnt),     32'b0010);
    check("sole.switch.y_valid", 32'(bus.y_valid), 32'd0);
    for (int j = 1; j <= 20; j++) begin
      step();
      check($sformatf("sole.j%0d.gnt", j), 32'(bus.gnt), 32'b0010);
      check($sformatf("sole.j%0d.cnt", j), 32'(bus.dbg_cnt), 32'(j % MH));
      check($sformatf("sole.j%0d.y", j), bus.y, 32'hFFFF_FFFF);
      check($sformatf("sole.j%0d.y_valid", j), 32'(bus.y_valid), 32'd1);
    end

    // Back to idle, then owner 0 with requester 3 waiting.
    drive_req(4'b0000);
    step();
    check("idle2.gnt", 32'(bus.gnt), 32'b0000);
    drive_req(4'b0001);   // last = 1, only req 0 -> owner 0
    step();
    check("rel.own0.gnt", 32'(bus.gnt), 32'b0001);
    drive_req(4'b1001);
    step();
    check("rel.hold.gnt", 32'(bus.gnt), 32'b0001);
    check("rel.hold.y",   bus.y,        32'h0000_0000);
    drive_req(4'b1000);   // owner 0 releases while 3 requests
    step();
    check_outputs("rel.switch", 4'b1000, 2'd3, 32'h0000_0000, 1'b0);
    step();
    check_outputs("rel.own3.data", 4'b1000, 2'd3, 32'h0000_FFFF, 1'b1);
    drive_req(4'b0000);   // owner releases with nobody else
    step();
    check_outputs("rel.idle", 4'b0000, 2'd3, 32'h0000_FFFF, 1'b0);

    // Reset mid-grant with owner 2.
    drive_req(4'b0100);
    step();
    check("mid.own2.gnt", 32'(bus.gnt), 32'b0100);
    step();
    check("mid.own2.y", bus.y, 32'hFFFF_0000);
    rst_n = 1'b0;
    step();
    check_outputs("mid.reset", 4'b0000, 2'd0, 32'h0, 1'b0);
    check("mid.reset.state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("mid.reset.cnt",   32'(bus.dbg_cnt),   32'd0);
    rst_n = 1'b1;
    drive_req(4'hF);
    step();
    check("mid.after.gnt", 32'(bus.gnt), 32'b0001);
    check("mid.after.sel", 32'(bus.sel), 32'd0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
